bitop16_pipe: RTL and testbench

BITOP16_PIPE -- requirements
Module: bitop16_pipe

---
 rtl/bitop16_pipe.sv | 116 +++++++++++
 tb/tb_bitop16_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bitop16_pipe.sv
// ============================================================================
// Module   : bitop16_pipe
// Function : 16-bit bitwise operation unit (AND/OR/XOR/AND-NOT) feeding a
//            DEPTH-entry result FIFO with valid/ready handshakes on both sides.
//            Optional per-entry zero/negative flags: BITOP16_PIPE_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitop16_pipe #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_OR   = 2'b01;
    localparam logic [1:0] c_OP_XOR  = 2'b10;
    localparam logic [1:0] c_OP_ANDN = 2'b11;

    localparam logic [c_CNT_W-1:0] c_COUNT_FULL = c_CNT_W'(DEPTH);

    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [15:0]        r_mem [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic [15:0] w_result;
    logic [15:0] w_head;

    // Handshake status comes straight from the count register, so out_ready
    // never reaches in_ready combinationally; a pop on a full FIFO frees the
    // slot only for the following cycle.
    assign in_ready  = (r_count != c_COUNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_result = 16'h0000;
        case (op)
            c_OP_AND:  w_result = a & b;
            c_OP_OR:   w_result = a | b;
            c_OP_XOR:  w_result = a ^ b;
            c_OP_ANDN: w_result = a & ~b;
            default:   w_result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign out    = out_valid ? w_head : 16'h0000;

`ifdef BITOP16_PIPE_FLAGS_EN
    logic r_zr_mem [DEPTH];
    logic r_ng_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_zr_mem[r_wr_ptr] <= (w_result == 16'h0000);
            r_ng_mem[r_wr_ptr] <= w_result[15];
        end
    end

    assign zr = out_valid && r_zr_mem[r_rd_ptr];
    assign ng = out_valid && r_ng_mem[r_rd_ptr];
`else
    assign zr = 1'b0;
    assign ng = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitop16_pipe.sv
// ============================================================================
// Module   : tb_bitop16_pipe
// Function : Self-checking bench for bitop16_pipe (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitop16_pipe;

    localparam int DEPTH = 2;
`ifdef BITOP16_PIPE_FLAGS_EN
    localparam bit c_FLAGS = 1'b1;
`else
    localparam bit c_FLAGS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr;
    logic        ng;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    bitop16_pipe #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input logic [15:0] exp);
        chk({name, " out_valid"}, {15'd0, out_valid}, 16'd1);
        chk({name, " out"}, out, exp);
        chk({name, " zr"}, {15'd0, zr}, {15'd0, c_FLAGS && (exp == 16'h0000)});
        chk({name, " ng"}, {15'd0, ng}, {15'd0, c_FLAGS && exp[15]});
    endtask

    task automatic chk_empty(input string name);
        chk({name, " out_valid"}, {15'd0, out_valid}, 16'd0);
        chk({name, " in_ready"}, {15'd0, in_ready}, 16'd1);
        chk({name, " out"}, out, 16'h0000);
        chk({name, " zr"}, {15'd0, zr}, 16'd0);
        chk({name, " ng"}, {15'd0, ng}, 16'd0);
    endtask

    task automatic drive(input logic v, input logic [15:0] da, input logic [15:0] db,
                         input logic [1:0] dop);
        in_valid = v;
        a        = da;
        b        = db;
        op       = dop;
    endtask

    initial begin
        vecs[0] = '{16'hF0F0, 16'hFF00, 2'b00, 16'hF000};
        vecs[1] = '{16'h1234, 16'h0FF0, 2'b01, 16'h1FF4};
        vecs[2] = '{16'h1234, 16'h0FF0, 2'b10, 16'h1DC4};
        vecs[3] = '{16'h1234, 16'h0FF0, 2'b11, 16'h1004};
        vecs[4] = '{16'h5555, 16'hAAAA, 2'b00, 16'h0000};
        vecs[5] = '{16'h5555, 16'hAAAA, 2'b01, 16'hFFFF};
        vecs[6] = '{16'h8001, 16'h8001, 2'b10, 16'h0000};
        vecs[7] = '{16'hFFFF, 16'h0000, 2'b11, 16'hFFFF};

        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 2'b00);
        tick();
        tick();
        reset = 1'b0;
        chk_empty("reset");

        // Single-transfer latency and one-cycle valid pulse per vector
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            chk($sformatf("vec%0d pre out_valid", i), {15'd0, out_valid}, 16'd0);
            tick();
            drive(1'b0, 16'h0, 16'h0, 2'b00);
            chk_head($sformatf("vec%0d", i), vecs[i].exp);
            tick();
            chk($sformatf("vec%0d pulse", i), {15'd0, out_valid}, 16'd0);
        end

        // Fill with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill%0d in_ready", i), {15'd0, in_ready}, 16'd1);
            drive(1'b1, 16'h1000 + 16'(i), 16'h0000, 2'b01);
            tick();
        end
        chk("full in_ready", {15'd0, in_ready}, 16'd0);
        drive(1'b1, 16'hDEAD, 16'h0000, 2'b01);
        tick();
        drive(1'b0, 16'h0, 16'h0, 2'b00);
        chk_head("hold0", 16'h1000);
        tick();
        chk_head("hold1", 16'h1000);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk_head($sformatf("drain%0d", i), 16'h1000 + 16'(i));
            tick();
        end
        chk_empty("drained");

        // Full FIFO with simultaneous push attempt and pop
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 16'h3000 + 16'(i), 16'h0000, 2'b01);
            tick();
        end
        drive(1'b1, 16'hBEEF, 16'h0000, 2'b01);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 16'h0, 16'h0, 2'b00);
        out_ready = 1'b0;
        chk("fullpop in_ready", {15'd0, in_ready}, 16'd1);
        chk_head("fullpop head", 16'h3001);
        out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            chk_head($sformatf("fullpop drain%0d", i), 16'h3000 + 16'(i));
            tick();
        end
        chk_empty("fullpop empty");

        // Steady push+pop at count=1 across several pointer wraps
        out_ready = 1'b0;
        drive(1'b1, 16'h2000, 16'h0000, 2'b01);
        tick();
        out_ready = 1'b1;
        for (int j = 0; j < 3 * DEPTH; j++) begin
            drive(1'b1, 16'h2000 + 16'(j + 1), 16'h0000, 2'b01);
            chk_head($sformatf("stream%0d", j), 16'h2000 + 16'(j));
            chk($sformatf("stream%0d in_ready", j), {15'd0, in_ready}, 16'd1);
            tick();
        end
        drive(1'b0, 16'h0, 16'h0, 2'b00);
        chk_head("stream last", 16'h2000 + 16'(3 * DEPTH));
        tick();
        chk_empty("stream empty");

        // Reset while holding entries and pushing
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), 16'h0000, 2'b01);
            tick();
        end
        drive(1'b1, 16'h7777, 16'h0000, 2'b01);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 2'b00);
        chk_empty("rst held");
        tick();
        chk_empty("rst held later");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
